romulus_pdi_packer: RTL and testbench

ROMULUS_PDI_PACKER -- requirements
Module: romulus_pdi_packer

---
 rtl/romulus_pdi_packer.sv | 156 +++++++++++++++
 tb/tb_romulus_pdi_packer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/romulus_pdi_packer.sv
// Packs 32-bit public-data words into padded 128-bit Romulus blocks with
// per-byte decrypt selects, block length and last/partial flags.
module romulus_pdi_packer #(
  parameter bit PADLEN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  bdi,
  input  logic         bdi_valid,
  output logic         bdi_ready,
  input  logic [2:0]   bdi_nbytes,
  input  logic         bdi_eot,
  input  logic         bdi_dec,
  output logic [127:0] pdi,
  output logic [15:0]  decrypt,
  output logic [4:0]   blk_len,
  output logic         blk_partial,
  output logic         blk_last,
  output logic         blk_valid,
  input  logic         blk_ready
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     w_q, w_d;
  logic [127:0]   buf_q, buf_d;
  logic [15:0]    dec_q, dec_d;
  logic [4:0]     len_q, len_d;
  logic           partial_q, partial_d;
  logic           last_q, last_d;
  logic [2:0]     n_eff_s;
  logic [4:0]     len_fin_s;
  logic           final_s;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] k);
    case (k)
      2'd0:    word_byte = word[31:24];
      2'd1:    word_byte = word[23:16];
      2'd2:    word_byte = word[15:8];
      2'd3:    word_byte = word[7:0];
      default: word_byte = 8'h00;
    endcase
  endfunction

  // Effective byte count of the presented word and resulting block length.
  always_comb begin
    if (!bdi_eot) begin
      n_eff_s = 3'd4;
    end else if (bdi_nbytes > 3'd4) begin
      n_eff_s = 3'd4;
    end else begin
      n_eff_s = bdi_nbytes;
    end
    len_fin_s = {1'b0, w_q, 2'b00} + {2'b00, n_eff_s};
    final_s   = bdi_eot || (w_q == 2'd3);
  end

  // Next-state and buffer update for the FILL/HOLD machine.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    buf_d     = buf_q;
    dec_d     = dec_q;
    len_d     = len_q;
    partial_d = partial_q;
    last_d    = last_q;
    case (state_q)
      ST_FILL: begin
        if (bdi_valid) begin
          for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 4; k++) begin
              if ((2'(j) == w_q) && (3'(k) < n_eff_s)) begin
                buf_d[127-32*j-8*k -: 8] = word_byte(bdi, 2'(k));
                dec_d[15-4*j-k]          = bdi_dec;
              end else if ((2'(j) == w_q) || (bdi_eot && (2'(j) > w_q))) begin
                buf_d[127-32*j-8*k -: 8] = 8'h00;
                dec_d[15-4*j-k]          = 1'b0;
              end else begin
                buf_d[127-32*j-8*k -: 8] = buf_q[127-32*j-8*k -: 8];
                dec_d[15-4*j-k]          = dec_q[15-4*j-k];
              end
            end
          end
          if (final_s) begin
            state_d   = ST_HOLD;
            w_d       = 2'd0;
            len_d     = len_fin_s;
            partial_d = (len_fin_s < 5'd16);
            last_d    = bdi_eot;
            // Length byte sits in the final byte slot, never marked for decrypt.
            if (PADLEN && (len_fin_s < 5'd16)) begin
              buf_d[7:0] = {3'b000, len_fin_s};
              dec_d[0]   = 1'b0;
            end else begin
              buf_d[7:0] = buf_d[7:0];
            end
          end else begin
            w_d = w_q + 2'd1;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_HOLD: begin
        if (blk_ready) begin
          state_d   = ST_FILL;
          w_d       = 2'd0;
          buf_d     = 128'd0;
          dec_d     = 16'd0;
          len_d     = 5'd0;
          partial_d = 1'b0;
          last_d    = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and block registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FILL;
      w_q       <= 2'd0;
      buf_q     <= 128'd0;
      dec_q     <= 16'd0;
      len_q     <= 5'd0;
      partial_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      buf_q     <= buf_d;
      dec_q     <= dec_d;
      len_q     <= len_d;
      partial_q <= partial_d;
      last_q    <= last_d;
    end
  end

  assign bdi_ready   = (state_q == ST_FILL);
  assign blk_valid   = (state_q == ST_HOLD);
  assign pdi         = buf_q;
  assign decrypt     = dec_q;
  assign blk_len     = len_q;
  assign blk_partial = partial_q;
  assign blk_last    = last_q;

endmodule

// File: tb/tb_romulus_pdi_packer.sv
// Scoreboard bench: a byte-queue reference model predicts each block; a monitor
// compares both PADLEN variants whenever a block is consumed.
module tb_romulus_pdi_packer;

  logic         clk, rst;
  logic [31:0]  bdi;
  logic         bdi_valid, bdi_eot, bdi_dec, blk_ready;
  logic [2:0]   bdi_nbytes;

  logic         u1_bdi_ready, u1_blk_partial, u1_blk_last, u1_blk_valid;
  logic [127:0] u1_pdi;
  logic [15:0]  u1_decrypt;
  logic [4:0]   u1_blk_len;
  logic         u0_bdi_ready, u0_blk_partial, u0_blk_last, u0_blk_valid;
  logic [127:0] u0_pdi;
  logic [15:0]  u0_decrypt;
  logic [4:0]   u0_blk_len;

  romulus_pdi_packer #(.PADLEN(1'b1)) u1 (
    .clk(clk), .rst(rst), .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(u1_bdi_ready),
    .bdi_nbytes(bdi_nbytes), .bdi_eot(bdi_eot), .bdi_dec(bdi_dec), .pdi(u1_pdi),
    .decrypt(u1_decrypt), .blk_len(u1_blk_len), .blk_partial(u1_blk_partial),
    .blk_last(u1_blk_last), .blk_valid(u1_blk_valid), .blk_ready(blk_ready));

  romulus_pdi_packer #(.PADLEN(1'b0)) u0 (
    .clk(clk), .rst(rst), .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(u0_bdi_ready),
    .bdi_nbytes(bdi_nbytes), .bdi_eot(bdi_eot), .bdi_dec(bdi_dec), .pdi(u0_pdi),
    .decrypt(u0_decrypt), .blk_len(u0_blk_len), .blk_partial(u0_blk_partial),
    .blk_last(u0_blk_last), .blk_valid(u0_blk_valid), .blk_ready(blk_ready));

  typedef struct {
    logic [127:0] pdi1;
    logic [127:0] pdi0;
    logic [15:0]  dec;
    logic [4:0]   len;
    logic         partial;
    logic         last;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] m_bytes[$];
  logic       m_decs[$];
  int         m_wc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         rdy_mode = 1;
  int         wt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: collect message bytes, emit a block every 4 words or at eot.
  task automatic model_word(input logic [31:0] d, input logic [2:0] nb, input logic eot, input logic dec);
    int   n;
    exp_t e;
    n = eot ? ((nb > 3'd4) ? 4 : int'(nb)) : 4;
    for (int k = 0; k < n; k++) begin
      m_bytes.push_back(d[31-8*k -: 8]);
      m_decs.push_back(dec);
    end
    m_wc++;
    if (eot || m_wc == 4) begin
      e.pdi0 = '0;
      e.dec  = '0;
      e.len  = 5'(m_bytes.size());
      for (int b = 0; b < m_bytes.size(); b++) begin
        e.pdi0[127-8*b -: 8] = m_bytes[b];
        e.dec[15-b]          = m_decs[b];
      end
      e.pdi1 = e.pdi0;
      if (m_bytes.size() < 16) e.pdi1[7:0] = 8'(m_bytes.size());
      e.partial = (m_bytes.size() < 16);
      e.last    = eot;
      sbq.push_back(e);
      m_bytes.delete();
      m_decs.delete();
      m_wc = 0;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] nb, input logic eot,
                      input logic dec, output int waited);
    logic acc;
    logic fin;
    fin        = eot || (m_wc == 3);
    bdi        = d;
    bdi_nbytes = nb;
    bdi_eot    = eot;
    bdi_dec    = dec;
    bdi_valid  = 1'b1;
    waited     = 0;
    acc        = 1'b0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = u1_bdi_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end else begin
      model_word(d, nb, eot, dec);
      chk("blk_valid_latency", u1_blk_valid, fin);
    end
    bdi_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    blk_ready = 1'b1;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    blk_ready = 1'b0;
    chk("drain_empty", 128'(sbq.size()), 128'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pdi1"}, u1_pdi, 128'd0);
    chk({tag, "_pdi0"}, u0_pdi, 128'd0);
    chk({tag, "_dec"}, u1_decrypt, 128'd0);
    chk({tag, "_len"}, u1_blk_len, 128'd0);
    chk({tag, "_partial"}, u1_blk_partial, 128'd0);
    chk({tag, "_last"}, u1_blk_last, 128'd0);
    chk({tag, "_valid"}, {u0_blk_valid, u1_blk_valid}, 128'd0);
    chk({tag, "_ready"}, {u0_bdi_ready, u1_bdi_ready}, 128'd3);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) blk_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pop on every consumed block; also check stability while held.
  initial begin
    logic [127:0] snap_pdi;
    logic [15:0]  snap_dec;
    logic [4:0]   snap_len;
    logic         snap_last;
    bit           armed;
    exp_t         e;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        armed = 1'b0;
      end else begin
        if (u1_blk_valid && armed) begin
          chk("hold_pdi", u1_pdi, snap_pdi);
          chk("hold_dec", u1_decrypt, snap_dec);
          chk("hold_len_last", {u1_blk_len, u1_blk_last}, {snap_len, snap_last});
        end
        if (u1_blk_valid && blk_ready) begin
          if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_block: got block expected none");
          end else begin
            e = sbq.pop_front();
            chk("pdi_padlen1", u1_pdi, e.pdi1);
            chk("pdi_padlen0", u0_pdi, e.pdi0);
            chk("decrypt", {u1_decrypt, u0_decrypt}, {e.dec, e.dec});
            chk("blk_len", {u1_blk_len, u0_blk_len}, {e.len, e.len});
            chk("blk_partial", {u1_blk_partial, u0_blk_partial}, {e.partial, e.partial});
            chk("blk_last", {u1_blk_last, u0_blk_last}, {e.last, e.last});
            chk("valid_pair", u0_blk_valid, 1'b1);
          end
          armed = 1'b0;
        end else begin
          armed     = u1_blk_valid;
          snap_pdi  = u1_pdi;
          snap_dec  = u1_decrypt;
          snap_len  = u1_blk_len;
          snap_last = u1_blk_last;
        end
      end
    end
  end

  initial begin
    logic [127:0] snap;
    int           nw;
    rst = 1'b0; bdi = 32'd0; bdi_valid = 1'b0; bdi_nbytes = 3'd0;
    bdi_eot = 1'b0; bdi_dec = 1'b0; blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", u1_bdi_ready, 1'b1);

    // Full encrypt block.
    send(32'h00010203, 3'd0, 1'b0, 1'b0, wt);
    send(32'h04050607, 3'd0, 1'b0, 1'b0, wt);
    send(32'h08090A0B, 3'd0, 1'b0, 1'b0, wt);
    send(32'h0C0D0E0F, 3'd0, 1'b0, 1'b0, wt);
    chk("t1_pdi", u1_pdi, 128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_len_part_last", {u1_blk_len, u1_blk_partial, u1_blk_last}, {5'd16, 1'b0, 1'b0});
    chk("t1_dec", u1_decrypt, 16'h0000);

    // Hold with a word pending.
    snap = u1_pdi;
    bdi = 32'h11223344; bdi_nbytes = 3'd0; bdi_eot = 1'b0; bdi_dec = 1'b1; bdi_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("hold_bdi_ready", u1_bdi_ready, 1'b0);
      chk("hold_pdi_fixed", u1_pdi, snap);
    end
    @(posedge clk);
    #1;
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    chk("consume_ready", u1_bdi_ready, 1'b1);
    chk("consume_valid", u1_blk_valid, 1'b0);
    chk("consume_cleared", {u1_pdi, u1_blk_len}, 133'd0);
    send(32'h11223344, 3'd0, 1'b0, 1'b1, wt);
    chk("accept_one_cycle", 128'(wt), 128'd1);

    // 15 valid bytes: length byte only with PADLEN=1.
    send(32'h55667788, 3'd0, 1'b0, 1'b0, wt);
    send(32'h99AABBCC, 3'd0, 1'b0, 1'b1, wt);
    send(32'hDDEEFF00, 3'd3, 1'b1, 1'b0, wt);
    chk("t15_pdi1", u1_pdi, 128'h112233445566778899AABBCCDDEEFF0F);
    chk("t15_pdi0", u0_pdi, 128'h112233445566778899AABBCCDDEEFF00);
    chk("t15_len", {u1_blk_len, u0_blk_len}, {5'd15, 5'd15});
    chk("t15_dec", u1_decrypt, 16'hF0F0);
    drain();

    // Partial decrypt block.
    send(32'hAABBCCDD, 3'd0, 1'b0, 1'b1, wt);
    send(32'hEEFF1122, 3'd3, 1'b1, 1'b1, wt);
    chk("t2_pdi", u1_pdi, 128'hAABBCCDDEEFF11000000000000000007);
    chk("t2_len_part_last", {u1_blk_len, u1_blk_partial, u1_blk_last}, {5'd7, 1'b1, 1'b1});
    chk("t2_dec", u1_decrypt, 16'hFE00);
    drain();

    // Empty message.
    send(32'hDEADBEEF, 3'd0, 1'b1, 1'b1, wt);
    chk("t3_pdi", {u1_pdi, u0_pdi}, 256'd0);
    chk("t3_len_part_last", {u1_blk_len, u1_blk_partial, u1_blk_last}, {5'd0, 1'b1, 1'b1});
    chk("t3_dec", u1_decrypt, 16'h0000);
    drain();

    // Reset mid-block.
    send(32'hCAFEBABE, 3'd0, 1'b0, 1'b1, wt);
    send(32'h12345678, 3'd0, 1'b0, 1'b0, wt);
    rst = 1'b0;
    #2;
    check_reset("midrst");
    m_bytes.delete();
    m_decs.delete();
    m_wc = 0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_midrst", u1_bdi_ready, 1'b1);
    send(32'h0F0E0D0C, 3'd0, 1'b0, 1'b1, wt);
    send(32'h0B0A0908, 3'd0, 1'b0, 1'b1, wt);
    send(32'h07060504, 3'd0, 1'b0, 1'b1, wt);
    send(32'h03020100, 3'd4, 1'b1, 1'b1, wt);
    chk("t4_pdi", u1_pdi, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t4_len_part_last", {u1_blk_len, u1_blk_partial, u1_blk_last}, {5'd16, 1'b0, 1'b1});
    chk("t4_dec", u1_decrypt, 16'hFFFF);
    drain();

    // Random messages with random backpressure, idles and oversize nbytes.
    rdy_mode = 0;
    for (int m = 0; m < 150; m++) begin
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send($urandom, 3'($urandom_range(0, 7)), (i == nw - 1), 1'($urandom_range(0, 1)), wt);
      end
    end
    rdy_mode = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
